mc_boot_ctrl: RTL
=================

Name: mc_boot_ctrl

Overview:
Boot and run sequencer for the 8-bit accumulator core (mc). On `start` it holds the core in reset and reads PROG_BYTES program bytes from an external SPI NOR flash (command 0x03). It feeds those bytes to the core through its loader port (loader_en/load/load_in), resets the core's PC and then gates its `run` input. Gating supports continuous run, single-instruction step and halting on an instruction boundary.

Parameters:
PROG_BYTES, 64, number of bytes fetched and loaded (1..64; the core has 64 words)
CLK_DIV, 2, SCK half-period in clk_i cycles (>=1)
FLASH_ADDR, 24'h000000, flash byte address of the first program byte
RD_CMD, 8'h03, SPI read opcode

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
start  input  1  level; sampled high in IDLE or READY begins a (re)boot
run_req  input  1  level; core runs continuously while high (READY only)
step_req  input  1  rising edge requests exactly one instruction (READY only)
spi_cs_n  output  1  flash chip select
spi_sck  output  1  flash clock, mode 0
spi_mosi  output  1  flash data out, MSB first
spi_miso  input  1  flash data in
mc_rst_n  output  1  to core rst_n
mc_loader_en  output  1  to core loader_en
mc_load  output  1  to core load
mc_load_data  output  8  to core load_in
mc_run  output  1  to core run
busy  output  1  boot in progress
ready  output  1  program loaded; run control active
halted  output  1  ready && !mc_run

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, mc_rst_n=0, mc_loader_en=0, mc_load=0, mc_load_data=0, mc_run=0, busy=0, ready=0, halted=0. Internal FSM=IDLE. Reset mid-boot aborts immediately and raises CS.
- FSM states: IDLE, CORE_RST0, SPI_HDR, SPI_BYTE, LD_SET, LD_PULSE, LD_GAP, CORE_RST1, READY.
- IDLE: mc_rst_n=0. start -> CORE_RST0, busy=1.
- CORE_RST0: mc_rst_n=0 for 2 cycles, then mc_rst_n=1, mc_loader_en=1, spi_cs_n=0 -> SPI_HDR.
- SPI_HDR: shift 32 bits {RD_CMD, FLASH_ADDR} MSB first.
  - mosi changes while sck low; sck toggles every CLK_DIV cycles.
  - First bit is valid at least CLK_DIV cycles before the first rising edge.
- SPI_BYTE: 8 sck periods. miso is sampled on each sck rising edge into a shift register. After the 8th falling edge, sck is held 0 and CS stays low -> LD_SET.
- LD_SET (1 cycle): mc_load_data <= received byte.
- LD_PULSE (1 cycle): mc_load=1.
- LD_GAP (1 cycle): mc_load=0. This guarantees the core sees a clean rising edge per byte.
- After LD_GAP, byte_cnt++. If byte_cnt < PROG_BYTES -> SPI_BYTE, else spi_cs_n=1, mc_loader_en=0 -> CORE_RST1.
- mc_load_data holds its value until the next LD_SET.
- CORE_RST1: mc_rst_n=0 for 2 cycles. This clears the core PC (left at PROG_BYTES by the loader) and the core phase bit. Then mc_rst_n=1 -> READY; busy=0, ready=1.
- READY run gating:
  - Internal phase bit mirrors the core's fetch/execute toggle; it flips on every cycle with mc_run=1.
  - mc_run=1 when run_req=1, OR a step is pending, OR phase=1 (instruction half-done).
  - Consequence: dropping run_req halts only at an instruction boundary, i.e. after an even number of run cycles.
  - step_req rising edge while halted -> mc_run high exactly 2 cycles. A step edge while running is ignored.
- start in READY: reboot at the next instruction boundary, then -> CORE_RST0; ready=0, busy=1.
- start held high has effect only from IDLE/READY. It is not re-triggered until the FSM returns there.
- Widths: byte_cnt 7 bits; bit counter 6 bits; clock divider counter wide enough for CLK_DIV.

Decomposition:
- Shared package mc_pkg: FSM state enum, MC_MEM_WORDS=64, default RD_CMD.
- Sub-module mc_spi_shift: bit-level SPI mode-0 shifter.
  - Ports: start, nbits, tx data, rx byte, done pulse.
  - Owns sck generation and the CLK_DIV counter.
- mc_boot_ctrl holds the FSM, byte counter, load handshake and run gating.

Test Plan:
- Boot with a flash model returning byte i = 8'hA0+i, PROG_BYTES=4, CLK_DIV=2 -> mosi carries 0x03,0x00,0x00,0x00. Then 4 mc_load pulses with data A0,A1,A2,A3, each 1 cycle high and preceded by 1 setup cycle. mc_rst_n low 2 cycles before ready=1, and core memory[0..3] = A0..A3.
- Full boot PROG_BYTES=64 with the mc instance attached and program `IN; OUT; JMP 0` -> after ready, run_req=1, port_out follows port_in within 4 cycles.
- run_req=1 for 5 cycles then 0 -> mc_run stays high 6 cycles total (boundary completion); halted=1 afterwards.
- Three step_req pulses while halted -> exactly 6 mc_run cycles; core PC advanced by 3 instructions. A step_req pulse while run_req=1 -> no extra run cycles.
- rst_i asserted mid-SPI_BYTE -> next cycle spi_cs_n=1, sck=0, mc_rst_n=0, busy=0. A new start re-issues the header from FLASH_ADDR.
- start pulse in READY while running -> completes current instruction, mc_run=0, busy=1, new header on SPI, no load pulses before the header completes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the mc boot/run sequencer: FSM states and core constants.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CORE_RST0,
        SPI_HDR,
        SPI_BYTE,
        LD_SET,
        LD_PULSE,
        LD_GAP,
        CORE_RST1,
        READY
    } state_e;

    localparam int         MC_MEM_WORDS = 64;
    localparam logic [7:0] MC_RD_CMD    = 8'h03;

endpackage

// File: rtl/mc_boot_ctrl_spi_shift.sv
// SPI mode-0 bit shifter: drives sck/mosi MSB first, samples miso on rising sck,
// pulses done_o on the final falling edge of an nbits_i-bit transfer.
module mc_spi_shift #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] tx_i,
    input  logic        miso_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic [7:0]  rx_o,
    output logic        done_o
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_q, active_d;
    logic             sck_q, sck_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       bits_q, bits_d;
    logic [31:0]      sh_q, sh_d;
    logic [7:0]       rx_q, rx_d;
    logic             tick;

    assign tick   = active_q && (div_q == DIV_LAST);
    // done_o is independent of start_i so the parent may chain the next transfer in the same cycle.
    assign done_o = tick && sck_q && (bits_q == 6'd1);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        active_d = active_q;
        sck_d    = sck_q;
        div_d    = div_q;
        bits_d   = bits_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        if (start_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = '0;
            bits_d   = nbits_i;
            sh_d     = tx_i;
        end else if (active_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                sck_d = !sck_q;
                if (!sck_q) begin
                    rx_d = {rx_q[6:0], miso_i};
                end else begin
                    sh_d   = {sh_q[30:0], 1'b0};
                    bits_d = bits_q - 6'd1;
                    if (bits_q == 6'd1) active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; state registers use non-blocking assignments only.
        if (rst_i) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = sh_q[31];
    assign rx_o   = rx_q;

endmodule

// File: rtl/mc_boot_ctrl.sv
// Boot and run sequencer for the mc core: fetches the program from SPI flash,
// loads it through the core loader port, then gates run on instruction boundaries.
module mc_boot_ctrl
    import mc_pkg::*;
#(
    parameter int          PROG_BYTES = MC_MEM_WORDS,
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter logic [7:0]  RD_CMD     = MC_RD_CMD
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic       run_req,
    input  logic       step_req,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       mc_rst_n,
    output logic       mc_loader_en,
    output logic       mc_load,
    output logic [7:0] mc_load_data,
    output logic       mc_run,
    output logic       busy,
    output logic       ready,
    output logic       halted
);

    state_e      state_q, state_d;
    logic        rst_cnt_q, rst_cnt_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d, byte_nxt;
    logic [7:0]  ld_data_q, ld_data_d;
    logic        phase_q, phase_d;
    logic        step_pend_q, step_pend_d;
    logic        step_prev_q;
    logic        reboot_q, reboot_d;
    logic        boot_req, step_rise, run;
    logic        spi_start, spi_done;
    logic [5:0]  spi_nbits;
    logic [31:0] spi_tx;
    logic [7:0]  spi_rx;

    assign boot_req  = start || reboot_q;
    assign step_rise = step_req && !step_prev_q;
    assign byte_nxt  = byte_cnt_q + 7'd1;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        ld_data_d   = ld_data_q;
        phase_d     = 1'b0;
        step_pend_d = 1'b0;
        reboot_d    = 1'b0;
        run         = 1'b0;
        spi_start   = 1'b0;
        spi_nbits   = 6'd8;
        spi_tx      = '0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = CORE_RST0;
                rst_cnt_d = 1'b0;
            end
            CORE_RST0: begin
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) begin
                    state_d    = SPI_HDR;
                    spi_start  = 1'b1;
                    spi_nbits  = 6'd32;
                    spi_tx     = {RD_CMD, FLASH_ADDR};
                    byte_cnt_d = '0;
                end
            end
            SPI_HDR: if (spi_done) begin
                state_d   = SPI_BYTE;
                spi_start = 1'b1;
            end
            SPI_BYTE: if (spi_done) begin
                state_d   = LD_SET;
                ld_data_d = spi_rx;
            end
            LD_SET:   state_d = LD_PULSE;
            LD_PULSE: state_d = LD_GAP;
            LD_GAP: begin
                byte_cnt_d = byte_nxt;
                if (byte_nxt < 7'(PROG_BYTES)) begin
                    state_d   = SPI_BYTE;
                    spi_start = 1'b1;
                end else begin
                    state_d   = CORE_RST1;
                    rst_cnt_d = 1'b0;
                end
            end
            CORE_RST1: begin
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) state_d = READY;
            end
            READY: begin
                if (boot_req && !phase_q) begin
                    state_d   = CORE_RST0;
                    rst_cnt_d = 1'b0;
                end else begin
                    // A pending reboot only lets the current instruction finish.
                    run         = phase_q || (!boot_req && (run_req || step_pend_q));
                    phase_d     = phase_q ^ run;
                    reboot_d    = boot_req;
                    step_pend_d = step_pend_q ? !(run && !phase_q) : (step_rise && !run);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rst_cnt_q   <= 1'b0;
            byte_cnt_q  <= '0;
            ld_data_q   <= '0;
            phase_q     <= 1'b0;
            step_pend_q <= 1'b0;
            step_prev_q <= 1'b0;
            reboot_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            ld_data_q   <= ld_data_d;
            phase_q     <= phase_d;
            step_pend_q <= step_pend_d;
            step_prev_q <= step_req;
            reboot_q    <= reboot_d;
        end
    end

    mc_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (spi_start),
        .nbits_i (spi_nbits),
        .tx_i    (spi_tx),
        .miso_i  (spi_miso),
        .sck_o   (spi_sck),
        .mosi_o  (spi_mosi),
        .rx_o    (spi_rx),
        .done_o  (spi_done)
    );

    assign spi_cs_n     = !(state_q inside {SPI_HDR, SPI_BYTE, LD_SET, LD_PULSE, LD_GAP});
    assign mc_loader_en = !spi_cs_n;
    assign mc_rst_n     = !(state_q inside {IDLE, CORE_RST0, CORE_RST1});
    assign mc_load      = (state_q == LD_PULSE);
    assign mc_load_data = ld_data_q;
    assign mc_run       = run;
    assign busy         = !(state_q inside {IDLE, READY});
    assign ready        = (state_q == READY);
    assign halted       = ready && !run;

endmodule
